// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and tag types for the sprite ROM arbiter
package sprite_pkg;
  localparam int SPRITE_ADDR_W = 17;
  localparam int PAL_IDX_W     = 4;
  localparam int MAX_REQ       = 8;
  localparam int REQ_ID_W      = $clog2(MAX_REQ);

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - round-robin pick: first active requester at or above rr_ptr, wrapping
module rr_priority_pick
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output req_id_t            idx
);

  always_comb begin
    int   cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = req_id_t'(cand);
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sharing of one sprite ROM with tagged, fixed-latency responses
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = SPRITE_ADDR_W,
  parameter  int DATA_W  = PAL_IDX_W,
  parameter  int ROM_LAT = 1,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      rvalid,
  output logic [ID_W-1:0]           rid,
  output logic [DATA_W-1:0]         rdata
);

  generate
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("sprite_rom_arbiter: NUM_REQ must be 2..8");
    end
    if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_rom_lat
      $error("sprite_rom_arbiter: ROM_LAT must be 1..3");
    end
    if (ADDR_W < 1 || DATA_W < 1) begin : g_bad_width
      $error("sprite_rom_arbiter: ADDR_W and DATA_W must be positive");
    end
  endgenerate

  req_id_t            rr_ptr;
  req_id_t            pick_idx;
  logic [NUM_REQ-1:0] req_live;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               any_gnt;
  tag_t               tag_pipe [ROM_LAT];

  // No grant may be shown while reset is held, even if requesters are active.
  assign req_live = (enable && reset_n) ? req : '0;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req_live),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );

  assign gnt     = pick_gnt;
  assign any_gnt = |pick_gnt;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      rom_address <= '0;
    end else if (any_gnt) begin
      rr_ptr      <= (pick_idx == req_id_t'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      rom_address <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    end
  end

  // The last tag stage lines up with rom_q becoming valid for that grant's address.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < ROM_LAT; s++) tag_pipe[s] <= '0;
      rvalid <= 1'b0;
      rid    <= '0;
      rdata  <= '0;
    end else begin
      tag_pipe[0] <= {any_gnt, pick_idx};
      for (int s = 1; s < ROM_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
      rvalid <= tag_pipe[ROM_LAT-1].valid;
      if (tag_pipe[ROM_LAT-1].valid) begin
        rid   <= tag_pipe[ROM_LAT-1].id[ID_W-1:0];
        rdata <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - directed scoreboard bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 17;
  localparam int DW = 4;
  localparam int IW = 2;

  typedef struct {
    int id;
    int data;
    int due;
  } exp_t;

  logic              vga_clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              enable;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      gnt;
  logic [AW-1:0]     rom_address;
  logic [DW-1:0]     rom_q;
  logic              rvalid;
  logic [IW-1:0]     rid;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     addr_tab [N];

  logic              en3;
  logic [N-1:0]      req3;
  logic [N*AW-1:0]   req_addr3;
  logic [N-1:0]      gnt3;
  logic [AW-1:0]     rom_address3;
  logic [DW-1:0]     rom_q3;
  logic              rvalid3;
  logic [IW-1:0]     rid3;
  logic [DW-1:0]     rdata3;
  logic [AW-1:0]     dl1, dl2;

  exp_t sb[$];
  exp_t head;
  logic exp_rv;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rv_count = 0;
  int   rv_base;
  int   c0;

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  always_comb begin
    req_addr = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_tab[i];
  end

  // ROM model: palette index is the low nibble of the address
  assign rom_q = rom_address[DW-1:0];

  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      dl1 <= '0;
      dl2 <= '0;
    end else begin
      dl1 <= rom_address3;
      dl2 <= dl1;
    end
  end
  assign rom_q3 = dl2[DW-1:0];

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rvalid      (rvalid),
    .rid         (rid),
    .rdata       (rdata)
  );

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut3 (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .enable      (en3),
    .req         (req3),
    .req_addr    (req_addr3),
    .gnt         (gnt3),
    .rom_address (rom_address3),
    .rom_q       (rom_q3),
    .rvalid      (rvalid3),
    .rid         (rid3),
    .rdata       (rdata3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic grant_step(input logic [N-1:0] r, input int exp_i, input string tag);
    exp_t e;
    req = r;
    @(negedge vga_clk);
    chk(tag, 32'(gnt), (exp_i < 0) ? 32'd0 : (32'd1 << exp_i));
    if (exp_i >= 0) begin
      e.id   = exp_i;
      e.data = int'(addr_tab[exp_i][DW-1:0]);
      e.due  = cyc + 2;
      sb.push_back(e);
    end
    tick();
  endtask

  // Response scoreboard: rvalid must appear exactly in the due cycle of the oldest entry
  always @(negedge vga_clk) begin
    exp_rv = (sb.size() != 0) && (sb[0].due == cyc);
    chk("rvalid", 32'(rvalid), 32'(exp_rv));
    if (rvalid) rv_count++;
    if (exp_rv) begin
      head = sb.pop_front();
      chk("rid", 32'(rid), head.id);
      chk("rdata", 32'(rdata), head.data);
    end
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    req       = '1;
    en3       = 1'b0;
    req3      = '0;
    req_addr3 = '0;
    for (int i = 0; i < N; i++) addr_tab[i] = AW'(100 + i);

    @(negedge vga_clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_rom_address", 32'(rom_address), 32'd0);
    chk("reset_rid", 32'(rid), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    tick();
    reset_n = 1'b1;

    for (int k = 0; k < 8; k++) grant_step('1, k % N, "rotate_gnt");
    grant_step('0, -1, "idle_gnt");
    grant_step('0, -1, "idle_gnt");

    addr_tab[2] = 17'h0012C;
    grant_step(4'b0100, 2, "single_gnt");
    req = '0;
    @(negedge vga_clk);
    chk("single_rom_address", 32'(rom_address), 32'h0012C);
    tick();
    grant_step('0, -1, "idle_gnt");

    addr_tab[0] = 17'h1010A;
    addr_tab[1] = 17'h00201;
    addr_tab[3] = 17'h0F30F;
    grant_step(4'b0010, 1, "fair_setup_gnt");
    grant_step(4'b1001, 3, "fair_a_gnt");
    grant_step(4'b1001, 0, "fair_b_gnt");
    grant_step(4'b1001, 3, "fair_c_gnt");
    for (int k = 0; k < 3; k++) grant_step('0, -1, "idle_gnt");

    rv_base = rv_count;
    grant_step('1, 0, "en_gnt0");
    grant_step('1, 1, "en_gnt1");
    grant_step('1, 2, "en_gnt2");
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req = '1;
      @(negedge vga_clk);
      chk("en_off_gnt", 32'(gnt), 32'd0);
      chk("en_off_rom_address", 32'(rom_address), 32'(addr_tab[2]));
      tick();
    end
    chk("en_off_pulses", rv_count - rv_base, 32'd3);

    enable      = 1'b1;
    addr_tab[0] = 17'h00010;
    grant_step(4'b0001, 0, "pre_reset_gnt");
    reset_n = 1'b0;
    sb.delete();
    @(negedge vga_clk);
    chk("in_reset_gnt", 32'(gnt), 32'd0);
    chk("in_reset_rom_address", 32'(rom_address), 32'd0);
    tick();
    @(negedge vga_clk);
    chk("in_reset_rid", 32'(rid), 32'd0);
    chk("in_reset_rdata", 32'(rdata), 32'd0);
    tick();
    reset_n = 1'b1;
    addr_tab[1] = 17'h00015;
    grant_step(4'b0011, 0, "post_reset_gnt");
    for (int k = 0; k < 3; k++) grant_step('0, -1, "idle_gnt");

    en3       = 1'b1;
    req3      = 4'b0001;
    req_addr3 = '0;
    req_addr3[AW-1:0] = 17'h00ABE;
    @(negedge vga_clk);
    chk("lat3_gnt", 32'(gnt3), 32'd1);
    c0 = cyc;
    tick();
    req3 = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge vga_clk);
      chk("lat3_rvalid", 32'(rvalid3), 32'(cyc == c0 + 4));
      if (cyc == c0 + 4) begin
        chk("lat3_rid", 32'(rid3), 32'd0);
        chk("lat3_rdata", 32'(rdata3), 32'hE);
      end
      tick();
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares one synchronous sprite/background ROM (17-bit address, 4-bit palette index) among up to NUM_REQ pixel-pipeline requesters, such as the background, player sprite and overlay layers.
Uses round-robin grant, registers the ROM address, and tracks in-flight reads in a tag pipeline. It returns each palette index tagged with the requester id.
Sits between the per-layer address generators and the single ROM instance, ahead of the palette lookup.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 17, ROM address width
DATA_W, 4, ROM data (palette index) width
ROM_LAT, 1, ROM read latency in vga_clk cycles, from rom_address change to rom_q valid (1..3)

Ports:
vga_clk  in  1  pixel clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
enable  in  1  grants permitted when high (frame active)
req  in  NUM_REQ  per-requester read request, level
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
rom_address  out  ADDR_W  registered ROM address
rom_q  in  DATA_W  ROM read data
rvalid  out  1  response valid, one-cycle pulse per grant
rid  out  $clog2(NUM_REQ)  requester id of response
rdata  out  DATA_W  registered rom_q for response

Behaviour:
- Reset (reset_n low, async):
  - gnt=0, rom_address=0, rvalid=0, rid=0, rdata=0, rr_ptr=0.
  - Tag pipeline cleared; in-flight reads are dropped and never return.
- Grant, cycle t:
  - If enable=1 and req≠0, gnt is one-hot on the first requester with req=1, searching upward from rr_ptr and wrapping at NUM_REQ-1→0.
  - enable=0 or req=0 gives gnt=0.
  - At most one grant per cycle; throughput is one read per cycle.
- Handshake:
  - A requester holds req and req_addr stable until it sees gnt in the same cycle.
  - It may deassert req, or present a new address, from cycle t+1.
  - req dropped without a grant is legal; nothing is issued.
- Pointer update: on a grant to i at edge end of t, rr_ptr <= (i+1) mod NUM_REQ. No grant leaves rr_ptr unchanged.
- Address: at edge end of t, rom_address <= req_addr[i] when granted, else it holds its value.
- Tag pipeline:
  - Depth ROM_LAT+1 of {valid, id}.
  - Stage 0 is loaded at edge end of t with {|gnt, idx}.
- Response:
  - rvalid=1, rid=i, rdata=rom_q (sampled at that edge) become visible in cycle t+ROM_LAT+1.
  - Fixed latency ROM_LAT+1 from grant cycle, no reordering.
  - rvalid is 0 in cycles with no matching grant; rdata holds its last value.
- enable falling: no new grants from that cycle; in-flight responses still complete.
- All requesters active continuously: strict rotation 0,1,..,NUM_REQ-1,0,... Worst-case wait is NUM_REQ-1 cycles.
- rom_q is assumed stable ROM_LAT cycles after rom_address changes. Any negedge ROM clocking is satisfied by the instantiating top and does not change the latency seen here.
- Invalid parameter values are rejected with an elaboration-time error.

Decomposition:
- sprite_pkg holds:
  - SPRITE_ADDR_W=17 and PAL_IDX_W=4 constants;
  - req_id_t typedef sized by max NUM_REQ=8;
  - tag_t struct {logic valid; req_id_t id;}.
- One sub-module, rr_priority_pick: combinational, inputs req and rr_ptr, outputs a one-hot gnt and binary idx. The arbiter instantiates it once; the tag pipeline and registers stay in sprite_rom_arbiter.

Test Plan:
- Reset mid-stream: grant req0 addr 0x00010, assert reset_n=0 the next cycle, then release → no rvalid ever appears for that read; rr_ptr=0; first grant after reset goes to lowest active req.
- Single requester: req=4'b0100, addr=0x0012C, ROM model returns addr[3:0] → gnt=4'b0100 in cycle 0, rom_address=0x0012C in cycle 1, rvalid/rid=2/rdata=0xC in cycle 2 (ROM_LAT=1).
- All four requesting continuously, addresses 100..103 → gnt sequence 0,1,2,3,0,...; rvalid every cycle; rid sequence 0,1,2,3 matching; rdata 4,5,6,7.
- Fairness after skip: rr_ptr=2, req=4'b1001 → gnt=req3, then req0, then req3 (req1/req2 idle).
- enable drop: 3 grants issued, then enable=0 with req=4'b1111 → gnt=0 immediately; exactly 3 rvalid pulses still arrive; rom_address holds.
- ROM_LAT=3 build: single grant at cycle 0 → rvalid only in cycle 4, correct rdata.
